// File: rtl/tgate_line_rx.sv
// tgate_line_rx: oversampled serial receiver for a switched line that treats float as idle.
// Defining TGATE_RX_PARITY_EN adds one even-parity bit between the data bits and the stop bit.
module tgate_line_rx #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              float_det
);
    localparam int PW = $clog2(OVERSAMPLE);
    localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef TGATE_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
    state_t            state, state_n;
    logic [PW-1:0]     phase, phase_n;
    logic [BW-1:0]     bit_idx, bit_n;
    logic [DATA_W-1:0] shreg;
    logic              line_q, last, shift_en, stop_smp, good, load;
    assign last = phase == PW'(OVERSAMPLE - 1);
`ifdef TGATE_RX_PARITY_EN
    logic par_smp, par_bad;
    assign good = stop_smp && line_q && !par_bad;
`else
    assign good = stop_smp && line_q;
`endif
    // A full buffer still accepts a new word when the consumer drains it this same cycle.
    assign load = good && (!rx_valid || rx_ready);
    always_comb begin
        state_n  = state;
        phase_n  = last ? '0 : phase + 1'b1;
        bit_n    = bit_idx;
        shift_en = 1'b0;
        stop_smp = 1'b0;
`ifdef TGATE_RX_PARITY_EN
        par_smp  = 1'b0;
`endif
        case (state)
            IDLE: begin
                phase_n = '0;
                state_n = line_q ? IDLE : START;
            end
            START: if (phase == PW'(OVERSAMPLE / 2 - 1)) begin
                phase_n = '0;
                bit_n   = '0;
                state_n = line_q ? IDLE : DATA;
            end
            DATA: if (last) begin
                shift_en = 1'b1;
                bit_n    = bit_idx + 1'b1;
                if (bit_idx == BW'(DATA_W - 1)) begin
                    bit_n = '0;
`ifdef TGATE_RX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef TGATE_RX_PARITY_EN
            PARITY: if (last) begin
                par_smp = 1'b1;
                state_n = STOP;
            end
`endif
            STOP: if (last) begin
                stop_smp = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            line_q    <= 1'b1;
            float_det <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Anything other than a solid 0 (including z/x) reads as the idle/mark level.
            line_q    <= (line_in === 1'b0) ? 1'b0 : 1'b1;
            float_det <= (line_in !== 1'b0) && (line_in !== 1'b1);
            state     <= state_n;
            phase     <= phase_n;
            bit_idx   <= bit_n;
            if (shift_en) shreg[bit_idx] <= line_q;
            if (load) rx_data <= shreg;
            rx_valid  <= load || (rx_valid && !rx_ready);
            frame_err <= stop_smp && !good;
            overrun   <= good && rx_valid && !rx_ready;
        end
    end
`ifdef TGATE_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) par_bad <= 1'b0;
        else if (par_smp) par_bad <= line_q != ^shreg;
    end
`endif
endmodule
